aes_byte_loader: RTL and testbench
==================================

Name: aes_byte_loader

Overview:
Upstream input stage for the AES encrypt/decrypt datapath. Accepts a byte-serial command stream over a valid/ready handshake and assembles the 128-bit key and 128-bit data block. Presents both to the datapath under a valid/ready output handshake. The key is retained across blocks, so a data-only command reuses the last loaded key.

Parameters:
BLOCK_BYTES, 16, bytes per 128-bit word; fixed, not to be overridden.
TIMEOUT_CYC, 1000000, inter-byte idle limit in clock cycles; used only when the optional feature is compiled in.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_byte  input  8  stream byte
in_valid  input  1  in_byte is valid
in_ready  output  1  loader can accept a byte
data  output  128  assembled plaintext block
key  output  128  assembled key
out_valid  output  1  data/key ready for the datapath
out_ready  input  1  datapath accepts data/key
busy  output  1  high in any state other than S_HDR
err_hdr  output  1  one-cycle pulse: bad header, or data-only command with no key loaded
err_timeout  output  1  one-cycle pulse on idle abort; tied 0 when the feature is compiled out

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: data=0, key=0, out_valid=0, in_ready=0 while rst is high, busy=0, err_hdr=0, err_timeout=0. Internal state: key_loaded=0, state=S_HDR, cnt=0.
- Byte accept: a byte is accepted when in_valid && in_ready at a rising edge.
- in_ready: 1 in S_HDR, S_KEY and S_DATA; 0 in S_OUT.
- Byte order: MSB-first, FIPS-197 order. Accepted byte shifts in as reg <= {reg[119:0], in_byte}, so the first byte ends up in [127:120].
- S_HDR:
  - 8'h4B ('K'): go to S_KEY, cnt=0.
  - 8'h44 ('D') with key_loaded=1: go to S_DATA, cnt=0.
  - 8'h44 with key_loaded=0: pulse err_hdr, stay in S_HDR.
  - Any other byte: pulse err_hdr, byte dropped, stay in S_HDR.
- S_KEY:
  - Each accepted byte shifts into key; cnt increments; cnt is 4 bits.
  - On the 16th byte (cnt==15): key_loaded <= 1, go to S_DATA, cnt <= 0.
- S_DATA:
  - Each accepted byte shifts into data.
  - On the 16th byte: go to S_OUT; out_valid is asserted the cycle after that byte is accepted.
- S_OUT:
  - data and key are held stable while out_valid=1.
  - When out_valid && out_ready: the next cycle has out_valid=0, state S_HDR, in_ready=1. Minimum turnaround is one cycle.
  - out_ready while out_valid=0 has no effect.
- Stability: key changes only in S_KEY; data changes only in S_DATA. Outputs are meaningful only while out_valid=1.
- Latency: out_valid rises exactly 1 cycle after the last data byte is accepted.
- in_valid may toggle freely. Gaps between bytes are allowed in every state.
- rst asserted mid-operation: immediate return to reset values. key_loaded clears, so a stored key is lost.

Optional Feature:
Macro: AES_LOADER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in S_KEY and S_DATA; it clears on each accepted byte and on state entry.
  - On reaching TIMEOUT_CYC-1: pulse err_timeout, go to S_HDR, cnt=0.
  - If the abort happens in S_KEY, key_loaded <= 0. If it happens in S_DATA, the previous key is kept.
  - S_HDR and S_OUT never time out.
- Undefined: no counter; the loader waits indefinitely; err_timeout is constant 0.

Decomposition:
- Package aes_loader_pkg holds:
  - state enum {S_HDR, S_KEY, S_DATA, S_OUT}
  - HDR_KEY=8'h4B, HDR_DATA=8'h44
  - BLOCK_BYTES=16
- Sub-module aes_idle_timer: parameterised down-counter with clear/enable and an expire pulse. Instantiated only under AES_LOADER_TIMEOUT_EN.
- The shift registers and FSM stay in the top module.

Test Plan:
- Full load: 'K', then key bytes 00..0F, then data bytes 00,11,..,FF, out_ready=1 → key=128'h000102030405060708090a0b0c0d0e0f, data=128'h00112233445566778899aabbccddeeff, out_valid high exactly 1 cycle.
- Key reuse: after the full load, send 'D' plus 16 bytes of 8'hAA → data=all AA, key unchanged, out_valid asserted.
- Backpressure: hold out_ready=0 for 20 cycles → out_valid, data and key stable; in_ready=0 throughout; release → S_HDR next cycle.
- Errors from reset: 'D' → err_hdr pulse, in_ready stays 1. Then 8'h00 → err_hdr pulse. Then a valid 'K' load → succeeds.
- Gaps and reset: in_valid toggling every other cycle during a load gives correct assembly. Asserting rst after key byte 7 clears all outputs, and a following 'D' gives err_hdr.
- Timeout (AES_LOADER_TIMEOUT_EN, TIMEOUT_CYC=50): stall 50 cycles after key byte 5 → err_timeout pulse, back in S_HDR, next 'D' gives err_hdr.

Source files
------------

// File: rtl/aes_loader_pkg.sv
// Shared types and constants for the AES byte-serial input loader.
package aes_loader_pkg;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_KEY  = 2'd1,
        S_DATA = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    localparam logic [7:0] HDR_KEY     = 8'h4B;
    localparam logic [7:0] HDR_DATA    = 8'h44;
    localparam int unsigned BLOCK_BYTES = 16;

endpackage

// File: rtl/aes_idle_timer.sv
// Idle down-counter: reloads on clear, counts while enabled, pulses expire
// in the cycle it has run LIMIT cycles without a clear.
module aes_idle_timer #(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = W'(LIMIT - 1);
        else if (en_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= W'(LIMIT - 1);
        else     cnt_q <= cnt_d;
    end

    assign expire_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/aes_byte_loader.sv
// Byte-serial key/data assembler feeding the AES datapath.
// Optional inter-byte idle abort is compiled in with AES_LOADER_TIMEOUT_EN.
module aes_byte_loader
    import aes_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] data,
    output logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         err_hdr,
    output logic         err_timeout
);

    if (TIMEOUT_CYC < 2) begin : g_cfg_chk
        $error("TIMEOUT_CYC must be at least 2");
    end

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] key_q, key_d, data_q, data_d;
    logic         key_loaded_q, key_loaded_d;
    logic         err_hdr_q, err_hdr_d;
    logic         err_tmo_q, err_tmo_d;
    logic         accept;
    logic         tmo_expire;

    assign accept = in_valid && in_ready;

`ifdef AES_LOADER_TIMEOUT_EN
    logic tmo_en;

    assign tmo_en = (state_q == S_KEY) || (state_q == S_DATA);

    // Holding clear outside KEY/DATA gives a full reload on state entry.
    aes_idle_timer #(.LIMIT(TIMEOUT_CYC)) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!tmo_en || accept),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        data_d       = data_q;
        key_loaded_d = key_loaded_q;
        err_hdr_d    = 1'b0;
        err_tmo_d    = 1'b0;
        case (state_q)
            S_HDR: begin
                if (accept) begin
                    if (in_byte == HDR_KEY) begin
                        state_d = S_KEY;
                        cnt_d   = '0;
                    end else if ((in_byte == HDR_DATA) && key_loaded_q) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        err_hdr_d = 1'b1;
                    end
                end
            end
            S_KEY: begin
                if (tmo_expire) begin
                    // A half-written key is unusable, so a later 'D' must be refused.
                    state_d      = S_HDR;
                    cnt_d        = '0;
                    key_loaded_d = 1'b0;
                    err_tmo_d    = 1'b1;
                end else if (accept) begin
                    key_d = {key_q[119:0], in_byte};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(BLOCK_BYTES - 1)) begin
                        key_loaded_d = 1'b1;
                        state_d      = S_DATA;
                        cnt_d        = '0;
                    end
                end
            end
            S_DATA: begin
                if (tmo_expire) begin
                    state_d   = S_HDR;
                    cnt_d     = '0;
                    err_tmo_d = 1'b1;
                end else if (accept) begin
                    data_d = {data_q[119:0], in_byte};
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'(BLOCK_BYTES - 1)) begin
                        state_d = S_OUT;
                        cnt_d   = '0;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_HDR;
            cnt_q        <= '0;
            key_q        <= '0;
            data_q       <= '0;
            key_loaded_q <= 1'b0;
            err_hdr_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            data_q       <= data_d;
            key_loaded_q <= key_loaded_d;
            err_hdr_q    <= err_hdr_d;
            err_tmo_q    <= err_tmo_d;
        end
    end

    // Gated with rst so no byte looks accepted while reset is held.
    assign in_ready    = !rst && (state_q != S_OUT);
    assign out_valid   = (state_q == S_OUT);
    assign busy        = (state_q != S_HDR);
    assign data        = data_q;
    assign key         = key_q;
    assign err_hdr     = err_hdr_q;
    assign err_timeout = err_tmo_q;

endmodule

// File: tb/tb_aes_byte_loader.sv
// Directed self-checking bench for aes_byte_loader (timeout scenario needs AES_LOADER_TIMEOUT_EN).
module tb_aes_byte_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         err_hdr;
    logic         err_timeout;

    int checks = 0;
    int errors = 0;

    aes_byte_loader #(.TIMEOUT_CYC(50)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data        (data),
        .key         (key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .err_hdr     (err_hdr),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Presents one byte for exactly one rising edge, returns 1 time unit after it.
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
        #2;
        checks++;
        if ({out_valid, in_ready, busy, err_hdr, err_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ov/ir/busy/eh/et=%b expected 00000",
                     {out_valid, in_ready, busy, err_hdr, err_timeout});
        end
        checks++;
        if (data !== 128'h0 || key !== 128'h0) begin
            errors++;
            $display("FAIL reset_regs: got data=%h key=%h expected zero", data, key);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b busy=%b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_full_load();
        out_ready = 1'b1;
        send_byte(8'h4B);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_hdr: got busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        checks++;
        if (out_valid !== 1'b0 || key !== 128'h000102030405060708090a0b0c0d0e0f) begin
            errors++;
            $display("FAIL full_key: got ov=%b key=%h expected 0 000102030405060708090a0b0c0d0e0f",
                     out_valid, key);
        end
        for (int i = 0; i < 15; i++) send_byte(8'(i * 17));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_early_valid: got out_valid=%b expected 0", out_valid);
        end
        send_byte(8'hFF);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
            data !== 128'h00112233445566778899aabbccddeeff) begin
            errors++;
            $display("FAIL full_out: got ov=%b ir=%b data=%h expected 1 0 00112233445566778899aabbccddeeff",
                     out_valid, in_ready, data);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_handshake: got ov=%b ir=%b busy=%b expected 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_key_reuse_backpressure();
        int bad;
        out_ready = 1'b0;
        send_byte(8'h44);
        for (int i = 0; i < 16; i++) send_byte(8'hAA);
        checks++;
        if (out_valid !== 1'b1 || data !== {16{8'hAA}} ||
            key !== 128'h000102030405060708090a0b0c0d0e0f) begin
            errors++;
            $display("FAIL reuse_out: got ov=%b data=%h key=%h expected 1 all-aa 000102..0f",
                     out_valid, data, key);
        end
        // Offered bytes while out_valid is held must be ignored.
        bad = 0;
        in_valid = 1'b1;
        in_byte  = 8'h55;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || data !== {16{8'hAA}} ||
                key !== 128'h000102030405060708090a0b0c0d0e0f || busy !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || err_hdr !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: got ov=%b ir=%b busy=%b eh=%b expected 0 1 0 0",
                     out_valid, in_ready, busy, err_hdr);
        end
    endtask

    task automatic test_errors();
        do_reset();
        out_ready = 1'b1;
        send_byte(8'h44);
        checks++;
        if (err_hdr !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_nokey: got eh=%b ir=%b busy=%b expected 1 1 0", err_hdr, in_ready, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (err_hdr !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_width: got err_hdr=%b expected 0", err_hdr);
        end
        send_byte(8'h00);
        checks++;
        if (err_hdr !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_badhdr: got eh=%b busy=%b expected 1 0", err_hdr, busy);
        end
        send_byte(8'h4B);
        for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i));
        for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
        checks++;
        if (out_valid !== 1'b1 || key !== 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf ||
            data !== 128'h303132333435363738393a3b3c3d3e3f) begin
            errors++;
            $display("FAIL err_recover: got ov=%b key=%h data=%h expected 1 a0a1..af 3031..3f",
                     out_valid, key, data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps_and_reset();
        out_ready = 1'b1;
        send_byte(8'h4B);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'hF0 + 8'(i));
            @(posedge clk); #1;
        end
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i * 16));
            if (i != 15) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (out_valid !== 1'b1 || key !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff ||
            data !== 128'h00102030405060708090a0b0c0d0e0f0) begin
            errors++;
            $display("FAIL gaps_assembly: got ov=%b key=%h data=%h expected 1 f0f1..ff 0010..f0",
                     out_valid, key, data);
        end
        @(posedge clk); #1;
        send_byte(8'h4B);
        for (int i = 0; i < 8; i++) send_byte(8'h70 + 8'(i));
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (key !== 128'h0 || data !== 128'h0 || out_valid !== 1'b0 ||
            in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: got key=%h data=%h ov=%b ir=%b busy=%b expected all zero",
                     key, data, out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send_byte(8'h44);
        checks++;
        if (err_hdr !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_keylost: got eh=%b busy=%b expected 1 0", err_hdr, busy);
        end
        @(posedge clk); #1;
    endtask

`ifdef AES_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int seen;
        do_reset();
        send_byte(8'h4B);
        for (int i = 0; i < 6; i++) send_byte(8'(i));
        seen = -1;
        for (int n = 1; n <= 60 && seen < 0; n++) begin
            @(posedge clk); #1;
            if (err_timeout === 1'b1) seen = n;
        end
        checks++;
        if (seen != 50 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: got pulse at idle cycle %0d busy=%b expected 50 0", seen, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width: got err_timeout=%b expected 0", err_timeout);
        end
        send_byte(8'h44);
        checks++;
        if (err_hdr !== 1'b1) begin
            errors++;
            $display("FAIL timeout_keylost: got err_hdr=%b expected 1", err_hdr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_key_reuse_backpressure();
        test_errors();
        test_gaps_and_reset();
`ifdef AES_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
